// File: rtl/pipedelayreg_var.sv
// pipedelayreg_var
//   Pipeline result register with a per-operation variable stall.
//   An operation that writes a real register (dst != 0) and asks for
//   lat != 0 cycles holds the pipeline for exactly lat cycles. The cycle
//   after those is the release cycle, where done is raised and the
//   pipeline advances.
//
// Ports
//   clk      in   rising-edge clock for all state
//   reset    in   synchronous active-high reset
//   d        in   result data, loaded into q whenever en=1
//   dst      in   destination register specifier (0 = no writeback)
//   lat      in   requested stall cycles for this operation
//   en       in   stage enable
//   squashn  in   active-low squash: clears q, aborts any stall
//   stalled  out  combinational stall request
//   busy     out  registered, high while a stall is in progress
//   done     out  combinational, high on the release cycle
//   q        out  registered result
module pipedelayreg_var #(
  parameter int WIDTH = 32,
  parameter int DSTW  = 5,
  parameter int LATW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic [DSTW-1:0]  dst,
  input  logic [LATW-1:0]  lat,
  input  logic             en,
  input  logic             squashn,
  output logic             stalled,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [LATW-1:0]  cnt_reg, cnt_next;
  logic [WIDTH-1:0] q_reg;
  logic             start;
  logic             cnt_zero;
  logic             kill;

  // Reset is treated exactly like a squash for the combinational outputs
  // and the next-state logic.
  assign kill     = reset | ~squashn;
  assign cnt_zero = (cnt_reg == '0);

  // Only an idle register can accept a new stall; the release cycle never
  // restarts, so an operation is never stalled twice.
  assign start = (state_reg == ST_IDLE) & en & (|dst) & (lat != '0) & ~kill;

  always_comb begin
    stalled    = 1'b0;
    done       = 1'b0;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (kill) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else if (state_reg == ST_IDLE) begin
      stalled = start;
      if (start) begin
        state_next = ST_WAIT;
        // The start cycle itself is the first stall cycle, hence lat-1.
        cnt_next   = lat - LATW'(1);
      end
    end else begin
      stalled = ~cnt_zero;
      done    = cnt_zero;
      if (cnt_zero) begin
        state_next = ST_IDLE;
      end else begin
        cnt_next = cnt_reg - LATW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // q loads on every enabled cycle, including while waiting; upstream holds
  // d stable during a stall so reloading is harmless.
  always_ff @(posedge clk) begin
    if (kill) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign busy = (state_reg == ST_WAIT);
  assign q    = q_reg;

endmodule

// File: tb/tb_pipedelayreg_var.sv
module tb_pipedelayreg_var;

  logic        clk;
  logic        reset;
  logic [31:0] d;
  logic [4:0]  dst;
  logic [2:0]  lat;
  logic        en;
  logic        squashn;
  logic        stalled;
  logic        busy;
  logic        done;
  logic [31:0] q;

  int total_checks = 0;
  int pass_checks  = 0;

  pipedelayreg_var #(.WIDTH(32), .DSTW(5), .LATW(3)) dut (
    .clk(clk), .reset(reset), .d(d), .dst(dst), .lat(lat), .en(en),
    .squashn(squashn), .stalled(stalled), .busy(busy), .done(done), .q(q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got === exp) begin
      pass_checks++;
    end else begin
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change just after a rising edge; combinational outputs are
  // sampled at the falling edge, registered outputs just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    int done_cnt;
    reset = 1'b1; en = 1'b1; dst = 5'd3; lat = 3'd4; d = 32'hAAAA_5555; squashn = 1'b1;
    #1;

    // Reset held two cycles with a valid stall request present
    for (int c = 0; c < 2; c++) begin
      mid();
      check($sformatf("rst_stalled_c%0d", c), {31'd0, stalled}, 32'd0);
      check($sformatf("rst_done_c%0d", c), {31'd0, done}, 32'd0);
      tick();
      check($sformatf("rst_q_c%0d", c), q, 32'd0);
      check($sformatf("rst_busy_c%0d", c), {31'd0, busy}, 32'd0);
    end
    reset = 1'b0; en = 1'b0; dst = 5'd0; lat = 3'd0;
    tick();

    // lat=1: identical to the fixed one-cycle register
    en = 1'b1; dst = 5'd5; lat = 3'd1; d = 32'hDEAD_BEEF;
    mid();
    check("lat1_c0_stalled", {31'd0, stalled}, 32'd1);
    check("lat1_c0_done", {31'd0, done}, 32'd0);
    tick();
    check("lat1_q", q, 32'hDEAD_BEEF);
    check("lat1_busy", {31'd0, busy}, 32'd1);
    mid();
    check("lat1_c1_stalled", {31'd0, stalled}, 32'd0);
    check("lat1_c1_done", {31'd0, done}, 32'd1);
    tick();
    en = 1'b0; dst = 5'd0; lat = 3'd0;
    check("lat1_after_busy", {31'd0, busy}, 32'd0);

    // lat=5: five stall cycles, release on cycle 5
    en = 1'b1; dst = 5'd7; lat = 3'd5; d = 32'h0000_0055;
    for (int c = 0; c <= 5; c++) begin
      mid();
      check($sformatf("lat5_stalled_c%0d", c), {31'd0, stalled}, (c < 5) ? 32'd1 : 32'd0);
      check($sformatf("lat5_done_c%0d", c), {31'd0, done}, (c == 5) ? 32'd1 : 32'd0);
      check($sformatf("lat5_busy_c%0d", c), {31'd0, busy}, (c >= 1) ? 32'd1 : 32'd0);
      tick();
    end
    en = 1'b0; dst = 5'd0; lat = 3'd0;
    mid();
    check("lat5_idle_busy", {31'd0, busy}, 32'd0);
    check("lat5_idle_stalled", {31'd0, stalled}, 32'd0);
    check("lat5_q", q, 32'h0000_0055);
    tick();

    // dst=0 with a nonzero latency: no stall, q still loads
    en = 1'b1; dst = 5'd0; lat = 3'd6; d = 32'h0000_ABCD;
    mid();
    check("dst0_stalled", {31'd0, stalled}, 32'd0);
    tick();
    check("dst0_q", q, 32'h0000_ABCD);
    check("dst0_busy", {31'd0, busy}, 32'd0);

    // Squash with en low clears q
    en = 1'b0; squashn = 1'b0;
    tick();
    check("sq_clear_q", q, 32'd0);
    squashn = 1'b1;

    // lat=0 with a real destination: no stall, q loads
    en = 1'b1; dst = 5'd2; lat = 3'd0; d = 32'h0000_1234;
    mid();
    check("lat0_stalled", {31'd0, stalled}, 32'd0);
    tick();
    check("lat0_q", q, 32'h0000_1234);
    check("lat0_busy", {31'd0, busy}, 32'd0);
    en = 1'b0;
    tick();

    // Squash on the third stalled cycle of a lat=7 operation
    en = 1'b1; dst = 5'd9; lat = 3'd7; d = 32'h0000_0077;
    for (int c = 0; c < 2; c++) begin
      mid();
      check($sformatf("sq7_stalled_c%0d", c), {31'd0, stalled}, 32'd1);
      tick();
    end
    squashn = 1'b0;
    mid();
    check("sq7_sq_stalled", {31'd0, stalled}, 32'd0);
    check("sq7_sq_done", {31'd0, done}, 32'd0);
    tick();
    check("sq7_q", q, 32'd0);
    check("sq7_busy", {31'd0, busy}, 32'd0);
    squashn = 1'b1; en = 1'b0; dst = 5'd0; lat = 3'd0;
    for (int c = 0; c < 6; c++) begin
      mid();
      check($sformatf("sq7_no_done_c%0d", c), {31'd0, done}, 32'd0);
      tick();
    end

    // Reset in the middle of a stall acts like a squash
    en = 1'b1; dst = 5'd1; lat = 3'd4; d = 32'h0000_0099;
    tick();
    check("rstmid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    mid();
    check("rstmid_stalled", {31'd0, stalled}, 32'd0);
    check("rstmid_done", {31'd0, done}, 32'd0);
    tick();
    check("rstmid_q", q, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0; en = 1'b0; dst = 5'd0; lat = 3'd0;
    tick();

    // Back-to-back: lat=3 then lat=2 with en held; the second op's inputs
    // appear during the first op's release cycle and must not restart there.
    done_cnt = 0;
    en = 1'b1; dst = 5'd4; lat = 3'd3; d = 32'h0000_0300;
    for (int c = 0; c <= 6; c++) begin
      if (c == 3) begin
        lat = 3'd2; d = 32'h0000_0200;
      end
      mid();
      if (done) done_cnt++;
      check($sformatf("b2b_stalled_c%0d", c), {31'd0, stalled},
            (c == 3 || c == 6) ? 32'd0 : 32'd1);
      check($sformatf("b2b_done_c%0d", c), {31'd0, done},
            (c == 3 || c == 6) ? 32'd1 : 32'd0);
      check($sformatf("b2b_busy_c%0d", c), {31'd0, busy},
            (c == 0 || c == 4) ? 32'd0 : 32'd1);
      tick();
    end
    en = 1'b0; dst = 5'd0; lat = 3'd0;
    check("b2b_done_count", done_cnt, 32'd2);
    check("b2b_q", q, 32'h0000_0200);
    mid();
    check("b2b_end_busy", {31'd0, busy}, 32'd0);
    tick();

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
